hazard_stall_controller: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline. Computes operand forwarding selects, load-use stalls and branch flushes.
- Also schedules the shared multi-cycle multiply/divide unit (MDU): issues mdu_start and holds dependent instructions in ID while the MDU is busy.
- Drives PC/IF-ID write enables and IF-ID/ID-EX flushes in Top. Keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_stall_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: operand forwarding,
// load-use stalls, branch flushes, MDU issue/busy tracking, and a
// saturating stall-cycle counter.
//
// state | meaning
// IDLE  | MDU free; an MDU op in ID may launch
// BUSY  | MDU op in flight; mfhi/mflo and new MDU ops wait in ID
module hazard_stall_controller #(
    parameter int MDU_LATENCY = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_mdu,
    input  logic             id_reads_hilo,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int CW = $clog2(MDU_LATENCY + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;
    logic          mdu_hazard;

    assign mdu_busy = (state == BUSY);

    // Hazard detection on the instruction currently in ID
    always_comb begin
        load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) ||
                      (id_uses_rt && (ex_rd == id_rt)));
        mdu_hazard = mdu_busy && (id_is_mdu || id_reads_hilo);
    end

    // Forwarding selects: MEM result is newer than WB, and $0 is never forwarded
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs))
                fwd_a = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs))
                fwd_a = 2'b01;

            if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rt))
                fwd_b = 2'b10;
            else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rt))
                fwd_b = 2'b01;
        end
    end

    // Pipeline control outputs, in priority order branch > load-use > MDU hazard > MDU issue
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_start  = 1'b0;
        if (!rst) begin
            if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use || mdu_hazard) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end else if ((state == IDLE) && id_is_mdu) begin
                mdu_start  = 1'b1;
            end
        end
    end

    // MDU next-state and latency down-counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mdu_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(MDU_LATENCY);
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // MDU state register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (!pc_write && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed testbench for hazard_stall_controller with MDU_LATENCY=8.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo;
    logic        ex_mem_read, mem_reg_write, wb_reg_write, branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mdu_start, mdu_busy;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_stall_controller #(.MDU_LATENCY(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_mdu = 0; id_reads_hilo = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        branch_taken = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        id_is_mdu = 1'b1;
        #1;
        check("rst_mdu_start", mdu_start, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", ifid_write, 1);
        check("rst_idex_flush", idex_flush, 0);
        tick();
        check("rst_mdu_busy_c1", mdu_busy, 0);
        tick();
        check("rst_mdu_busy_c2", mdu_busy, 0);
        check("rst_stall_count", stall_count, 0);
        rst = 1'b0;
        clr();
        #1;

        // Forwarding
        ex_rs = 19; mem_rd = 19; mem_reg_write = 1; wb_rd = 19; wb_reg_write = 1; ex_rt = 5;
        #1;
        check("fwd_a_mem_beats_wb", fwd_a, 2'b10);
        check("fwd_b_no_match", fwd_b, 2'b00);
        mem_reg_write = 0;
        #1;
        check("fwd_a_wb", fwd_a, 2'b01);
        ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1;
        #1;
        check("fwd_a_zero_reg", fwd_a, 2'b00);
        ex_rt = 7; wb_rd = 7; mem_rd = 3;
        #1;
        check("fwd_b_wb", fwd_b, 2'b01);
        mem_rd = 7;
        #1;
        check("fwd_b_mem", fwd_b, 2'b10);
        check("fwd_no_stall", pc_write, 1);
        clr();

        // Load-use on rs
        ex_mem_read = 1; ex_rd = 20; id_uses_rs = 1; id_rs = 20;
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_ifid_flush", ifid_flush, 0);
        check("lu_no_mdu_start", mdu_start, 0);
        tick();
        clr();
        #1;
        check("lu_released", pc_write, 1);
        check("lu_stall_count", stall_count, 1);
        ex_mem_read = 1; ex_rd = 0; id_uses_rs = 1; id_rs = 0;
        #1;
        check("lu_rd0_no_stall", pc_write, 1);
        ex_rd = 20; id_uses_rs = 0; id_rs = 20;
        #1;
        check("lu_rs_unused_no_stall", pc_write, 1);
        id_uses_rt = 1; id_rt = 20;
        #1;
        check("lu_rt_stall", pc_write, 0);
        clr();
        #1;

        // Branch priority over load-use and MDU issue
        branch_taken = 1; ex_mem_read = 1; ex_rd = 20; id_uses_rs = 1; id_rs = 20; id_is_mdu = 1;
        #1;
        check("br_ifid_flush", ifid_flush, 1);
        check("br_idex_flush", idex_flush, 1);
        check("br_pc_write", pc_write, 1);
        check("br_ifid_write", ifid_write, 1);
        check("br_mdu_start", mdu_start, 0);
        tick();
        clr();
        #1;
        check("br_stall_count", stall_count, 1);
        check("br_no_busy", mdu_busy, 0);

        // MDU issue then dependent mfhi
        id_is_mdu = 1;
        #1;
        check("mdu_start", mdu_start, 1);
        check("mdu_start_pc_write", pc_write, 1);
        tick();
        id_is_mdu = 0; id_reads_hilo = 1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mfhi_busy_%0d", i), mdu_busy, 1);
            check($sformatf("mfhi_stall_%0d", i), pc_write, 0);
            check($sformatf("mfhi_idex_flush_%0d", i), idex_flush, 1);
            check($sformatf("mfhi_no_start_%0d", i), mdu_start, 0);
            tick();
        end
        check("mfhi_busy_done", mdu_busy, 0);
        check("mfhi_proceeds", pc_write, 1);
        check("mfhi_stall_count", stall_count, 9);

        // Back-to-back MDU op issues in the first non-busy cycle
        id_reads_hilo = 0; id_is_mdu = 1;
        #1;
        check("b2b_mdu_start", mdu_start, 1);
        tick();
        clr();
        #1;
        check("b2b_busy_1", mdu_busy, 1);
        check("b2b_no_hazard", pc_write, 1);
        tick();
        branch_taken = 1; id_reads_hilo = 1;
        #1;
        check("br_over_mdu_pc_write", pc_write, 1);
        check("br_over_mdu_ifid_flush", ifid_flush, 1);
        tick();
        clr();
        tick();
        check("b2b_busy_4", mdu_busy, 1);
        id_is_mdu = 1;
        #1;
        check("busy_no_start", mdu_start, 0);
        id_is_mdu = 0;

        // Mid-op reset
        rst = 1;
        #1;
        check("midrst_pc_write", pc_write, 1);
        tick();
        rst = 0;
        #1;
        check("midrst_busy_cleared", mdu_busy, 0);
        check("midrst_stall_count", stall_count, 0);
        id_is_mdu = 1;
        #1;
        check("midrst_mdu_start", mdu_start, 1);
        tick();
        clr();
        #1;
        check("midrst_new_busy", mdu_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
